bram_dual: RTL
==============

# bram_dual

Parametrised on-chip block RAM with two requester ports: a read-only instruction port and a read/write data port. Both ports share one single-ported storage array through a round-robin arbiter, and each port has an optional programmable wait-state delay. The block sits between the core's fetch and load/store units and replaces the single shared valid/ready memory. It keeps the same one-request-per-handshake protocol on each port.

## Interface
- XLEN, 32: data width in bits; multiple of 8, 32 or 64.
- DEPTH, 10: log2 of the word count; the array holds 2**DEPTH words of XLEN bits.
- WAIT, 0: extra wait cycles per access, 0..15.
- INIT_FILE, "": if non-empty, the array is loaded by $readmemh at time zero.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  instruction request strobe.
- i_addr  in  32  instruction byte address.
- i_rdata  out  XLEN  instruction read data.
- i_ready  out  1  instruction completion pulse.
- d_valid  in  1  data request strobe.
- d_addr  in  32  data byte address.
- d_wdata  in  XLEN  write data.
- d_wstrb  in  XLEN/8  byte write enables; all zero means a read.
- d_rdata  out  XLEN  data read data.
- d_ready  out  1  data completion pulse.
- err  out  1  sticky protocol-violation flag.

## Operation
- Word index is addr[DEPTH+B-1 : B], where B = log2(XLEN/8). Upper address bits and low byte-offset bits are ignored, so addresses wrap modulo the array size.
- Per-port state:
  - busy flag, plus a pending record (addr, wdata, wstrb).
  - A valid is accepted when the port is not busy, or in the same cycle that the port's ready is high.
  - An accepted valid sets busy, which clears in the cycle ready is emitted.
  - A valid while busy and not ready is dropped and sets err.
- Candidates each cycle: ports with a pending record, plus a port whose valid is accepted this cycle (bypass, no extra cycle).
- Engine FSM, two states:
  - IDLE: if at least one candidate exists, grant one and perform the access at this edge.
    - WAIT=0: stay in IDLE.
    - WAIT>0: go to HOLD with cnt=WAIT.
  - HOLD: decrement cnt each cycle; at cnt==1 return to IDLE. No grants are made in HOLD.
- Arbitration: round-robin pointer naming the preferred port.
  - Reset value: data port preferred.
  - After any grant where both ports were candidates, the pointer moves to the loser.
  - A single candidate is granted immediately and leaves the pointer unchanged.
  - The loser stays pending.
- Access at the grant edge:
  - The selected word is read before write: rdata returns the old contents.
  - Bytes with a set wstrb are written.
  - The instruction port never writes.
- Result: the granted port's rdata register is loaded and ready pulses for exactly one cycle, 1+WAIT cycles after the grant edge. rdata holds until that port's next ready.
- Memory contents are not affected by reset.

## Timing
- Reset values: i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, err=0, busy=0, pending=0, FSM=IDLE, cnt=0, pointer=data.
- Reset asserted mid-operation: all pending requests are discarded and no ready is emitted for them. Writes completed at earlier edges persist. No write occurs while rst=1.
- Latency, uncontended: valid at cycle n gives ready at cycle n+1+WAIT.
- Throughput: one array access per 1+WAIT cycles, shared by both ports.
- A single port issuing back-to-back (new valid in each ready cycle) at WAIT=0 gets one access per cycle.
- Contention: the loser is granted at the first IDLE edge after the winner's access, giving ready at n+2+2*WAIT.
- Simultaneous new valid and ready on the same port is legal; the new request becomes a candidate that cycle.
- err is set at the edge following a violation and stays 1 until rst.

## Test plan
- WAIT=0, INIT word 5 = 0xDEADBEEF; i_valid, i_addr=0x14 at cycle 3 -> i_ready=1 at cycle 4 with i_rdata=0xDEADBEEF; i_ready=0 at cycle 5.
- d write addr 0x20, wdata 0x11223344, wstrb 0b0101, old word 0xAABBCCDD -> d_rdata=0xAABBCCDD next cycle; a following read of 0x20 returns 0xAA22CC44.
- After reset, both valid in the same cycle n, WAIT=0 -> d_ready at n+1, i_ready at n+2. Repeat the simultaneous valids at a later cycle m -> i_ready at m+1, d_ready at m+2 (pointer moved to the instruction port).
- WAIT=3, single d read at cycle n -> d_ready exactly at n+4. A second d_valid at n+2 -> err=1 from n+3 and that request is ignored (exactly one ready).
- d_addr=0x0000_1000 with DEPTH=10, XLEN=32 aliases word 0: write 0x5A via wstrb 0b0001, then read 0x0 -> low byte 0x5A.
- Assert rst while i is pending behind a d access, WAIT=2 -> neither ready is seen, all outputs are 0, and a fresh request after reset is served normally.

Source files
------------

// File: rtl/bram_dual_if.sv
// bram_dual_if: requester-side bundle for the dual-port block RAM.
//   Instruction port : i_valid, i_addr -> i_rdata, i_ready
//   Data port        : d_valid, d_addr, d_wdata, d_wstrb -> d_rdata, d_ready
//   err              : sticky protocol-violation flag from the memory
// modport master is used by a requester or testbench, and modport slave by bram_dual.
interface bram_dual_if #(
    parameter int XLEN = 32
);
    logic              i_valid;
    logic [31:0]       i_addr;
    logic [XLEN-1:0]   i_rdata;
    logic              i_ready;
    logic              d_valid;
    logic [31:0]       d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_wstrb;
    logic [XLEN-1:0]   d_rdata;
    logic              d_ready;
    logic              err;

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
        input  i_rdata, i_ready, d_rdata, d_ready, err
    );

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
        output i_rdata, i_ready, d_rdata, d_ready, err
    );
endinterface

// File: rtl/bram_dual.sv
// bram_dual: one single-ported word array shared by two ports.
// The instruction port is read-only. The data port can read and write.
// Access to the array is round-robin arbitrated between the two ports.
// Each access can be followed by WAIT hold cycles.
// Ports:
//   clk  - clock; all state changes on its rising edge
//   rst  - asynchronous active-high reset (array contents are kept)
//   bus  - bram_dual_if.slave carrying both request ports and err
// Parameters: XLEN data width, DEPTH log2 word count, WAIT hold cycles (0..15),
//             INIT_FILE optional initial image name.
module bram_dual #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 10,
    parameter int WAIT      = 0,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    bram_dual_if.slave  bus
);
    localparam int NB    = XLEN / 8;
    localparam int B     = $clog2(NB);
    localparam int WORDS = 1 << DEPTH;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic { S_IDLE = 1'b0, S_HOLD = 1'b1 } state_t;
    typedef enum logic { P_DATA = 1'b0, P_INSN = 1'b1 } port_t;

    logic [XLEN-1:0] mem [WORDS];

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    port_t             ptr_reg;      // preferred port when both contend
    port_t             res_reg;      // owner of the access being held
    logic              i_busy_reg, d_busy_reg;
    logic              i_pend_reg, d_pend_reg;
    logic [DEPTH-1:0]  i_paddr_reg, d_paddr_reg;
    logic [XLEN-1:0]   d_pwdata_reg;
    logic [NB-1:0]     d_pwstrb_reg;
    logic              i_ready_reg, d_ready_reg;
    logic [XLEN-1:0]   i_hold_reg, d_hold_reg;
    logic [XLEN-1:0]   rd_reg;       // array read register, loaded only on a grant
    logic              err_reg;

    // Handshake: a request is taken when the port is free, or when its
    // previous request completes in the same cycle.
    logic i_acc, d_acc, i_drop, d_drop;
    assign i_acc  = bus.i_valid && (!i_busy_reg || i_ready_reg);
    assign d_acc  = bus.d_valid && (!d_busy_reg || d_ready_reg);
    assign i_drop = bus.i_valid && i_busy_reg && !i_ready_reg;
    assign d_drop = bus.d_valid && d_busy_reg && !d_ready_reg;

    // Candidate requests. A request accepted this cycle bypasses the pending record.
    logic              i_cand, d_cand, both_cand;
    logic [DEPTH-1:0]  i_idx, d_idx, g_idx;
    logic [XLEN-1:0]   d_wdata_c;
    logic [NB-1:0]     d_wstrb_c, g_wstrb;
    assign i_cand    = i_pend_reg || i_acc;
    assign d_cand    = d_pend_reg || d_acc;
    assign both_cand = i_cand && d_cand;
    assign i_idx     = i_pend_reg ? i_paddr_reg  : bus.i_addr[DEPTH+B-1:B];
    assign d_idx     = d_pend_reg ? d_paddr_reg  : bus.d_addr[DEPTH+B-1:B];
    assign d_wdata_c = d_pend_reg ? d_pwdata_reg : bus.d_wdata;
    assign d_wstrb_c = d_pend_reg ? d_pwstrb_reg : bus.d_wstrb;

    logic grant_i, grant_d, do_access;
    assign grant_d   = (state_reg == S_IDLE) && d_cand && (!i_cand || ptr_reg == P_DATA);
    assign grant_i   = (state_reg == S_IDLE) && i_cand && !grant_d;
    assign g_idx     = grant_d ? d_idx : i_idx;
    assign g_wstrb   = grant_d ? d_wstrb_c : '0;
    assign do_access = (grant_i || grant_d) && !rst;

    // Array port: read-before-write, byte-granular write. No reset, so
    // contents survive a reset.
    always_ff @(posedge clk) begin
        if (do_access) begin
            rd_reg <= mem[g_idx];
            for (int b = 0; b < NB; b++) begin
                if (g_wstrb[b]) mem[g_idx][8*b +: 8] <= d_wdata_c[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= P_DATA;
            res_reg      <= P_DATA;
            i_busy_reg   <= 1'b0;
            d_busy_reg   <= 1'b0;
            i_pend_reg   <= 1'b0;
            d_pend_reg   <= 1'b0;
            i_paddr_reg  <= '0;
            d_paddr_reg  <= '0;
            d_pwdata_reg <= '0;
            d_pwstrb_reg <= '0;
            i_ready_reg  <= 1'b0;
            d_ready_reg  <= 1'b0;
            i_hold_reg   <= '0;
            d_hold_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;

            // rd_reg can be overwritten by the other port's next grant.
            // Keep a per-port copy of the word just returned.
            if (i_ready_reg) i_hold_reg <= rd_reg;
            if (d_ready_reg) d_hold_reg <= rd_reg;

            if (i_drop || d_drop) err_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (grant_i || grant_d) begin
                        if (both_cand) ptr_reg <= grant_d ? P_INSN : P_DATA;
                        if (WAIT == 0) begin
                            i_ready_reg <= grant_i;
                            d_ready_reg <= grant_d;
                        end else begin
                            state_reg <= S_HOLD;
                            cnt_reg   <= WAIT_CNT;
                            res_reg   <= grant_i ? P_INSN : P_DATA;
                        end
                    end
                end
                S_HOLD: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= S_IDLE;
                        if (res_reg == P_INSN) i_ready_reg <= 1'b1;
                        else                   d_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (i_acc)            i_busy_reg <= 1'b1;
            else if (i_ready_reg) i_busy_reg <= 1'b0;
            if (d_acc)            d_busy_reg <= 1'b1;
            else if (d_ready_reg) d_busy_reg <= 1'b0;

            // Keep a record only for a request that lost arbitration or arrived during HOLD.
            if (i_acc && !grant_i) begin
                i_pend_reg  <= 1'b1;
                i_paddr_reg <= bus.i_addr[DEPTH+B-1:B];
            end else if (grant_i) begin
                i_pend_reg  <= 1'b0;
            end
            if (d_acc && !grant_d) begin
                d_pend_reg   <= 1'b1;
                d_paddr_reg  <= bus.d_addr[DEPTH+B-1:B];
                d_pwdata_reg <= bus.d_wdata;
                d_pwstrb_reg <= bus.d_wstrb;
            end else if (grant_d) begin
                d_pend_reg   <= 1'b0;
            end
        end
    end

    assign bus.i_ready = i_ready_reg;
    assign bus.d_ready = d_ready_reg;
    assign bus.i_rdata = i_ready_reg ? rd_reg : i_hold_reg;
    assign bus.d_rdata = d_ready_reg ? rd_reg : d_hold_reg;
    assign bus.err     = err_reg;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr, bus.d_addr};
endmodule
